// File: rtl/int_mult_pipe_if.sv
// Request/response and int_mult-side signals of the multiplier issue/return stage.
// The slave modport is the pipe itself; the master side drives requests and models int_mult.
interface int_mult_pipe_if #(
    parameter int TAG_WIDTH = 5
) ();
    logic                 req_i;
    logic                 gnt_o;
    logic [2:0]           operator_i;
    logic [31:0]          op_a_i;
    logic [31:0]          op_b_i;
    logic [31:0]          op_c_i;
    logic [4:0]           imm_i;
    logic                 short_subword_i;
    logic [1:0]           short_signed_i;
    logic [TAG_WIDTH-1:0] tag_i;

    logic [2:0]           mul_operator_o;
    logic [31:0]          mul_op_a_o;
    logic [31:0]          mul_op_b_o;
    logic [31:0]          mul_op_c_o;
    logic [4:0]           mul_imm_o;
    logic                 mul_short_subword_o;
    logic [1:0]           mul_short_signed_o;
    logic [31:0]          mul_result_i;

    logic                 rvalid_o;
    logic                 rready_i;
    logic [31:0]          result_o;
    logic [TAG_WIDTH-1:0] tag_o;
    logic                 err_o;
    logic                 busy_o;

    modport slave (
        input  req_i, operator_i, op_a_i, op_b_i, op_c_i, imm_i,
               short_subword_i, short_signed_i, tag_i, mul_result_i, rready_i,
        output gnt_o, mul_operator_o, mul_op_a_o, mul_op_b_o, mul_op_c_o, mul_imm_o,
               mul_short_subword_o, mul_short_signed_o, rvalid_o, result_o, tag_o,
               err_o, busy_o
    );

    modport master (
        output req_i, operator_i, op_a_i, op_b_i, op_c_i, imm_i,
               short_subword_i, short_signed_i, tag_i, mul_result_i, rready_i,
        input  gnt_o, mul_operator_o, mul_op_a_o, mul_op_b_o, mul_op_c_o, mul_imm_o,
               mul_short_subword_o, mul_short_signed_o, rvalid_o, result_o, tag_o,
               err_o, busy_o
    );
endinterface

// File: rtl/int_mult_pipe.sv
// Issue/return pipeline around the shared int_mult: S0 registers the operands feeding
// int_mult, S1..S(LATENCY-1) carry result/tag/err back with backpressure and bubble collapsing.
module int_mult_pipe #(
    parameter int LATENCY   = 2,
    parameter int TAG_WIDTH = 5
) (
    input logic            clk_i,
    input logic            rst_i,
    int_mult_pipe_if.slave io
);
    localparam logic [2:0] MUL_MAC32 = 3'b000;
    localparam logic [2:0] MUL_MSU32 = 3'b001;
    localparam logic [2:0] MUL_I     = 3'b010;
    localparam logic [2:0] MUL_IR    = 3'b011;

    function automatic logic op_unsupported(input logic [2:0] op);
        return !(op inside {MUL_MAC32, MUL_MSU32, MUL_I, MUL_IR});
    endfunction

    logic                 vld_p0_q, vld_p0_d;
    logic [2:0]           op_p0_q, op_p0_d;
    logic [31:0]          a_p0_q, a_p0_d;
    logic [31:0]          b_p0_q, b_p0_d;
    logic [31:0]          c_p0_q, c_p0_d;
    logic [4:0]           imm_p0_q, imm_p0_d;
    logic                 sub_p0_q, sub_p0_d;
    logic [1:0]           sgn_p0_q, sgn_p0_d;
    logic [TAG_WIDTH-1:0] tag_p0_q, tag_p0_d;

    // Per-stage views; index 0 is S0 as seen through the combinational int_mult.
    logic [LATENCY-1:0]   vld;
    logic [LATENCY-1:0]   adv;
    logic [LATENCY-1:0]   err;
    logic [31:0]          res [LATENCY];
    logic [TAG_WIDTH-1:0] tag [LATENCY];
    logic                 gnt;
    logic                 accept;

    assign vld[0] = vld_p0_q;
    assign err[0] = op_unsupported(op_p0_q);
    assign res[0] = err[0] ? 32'h0 : io.mul_result_i;
    assign tag[0] = tag_p0_q;

    // A stage may move on when its successor is empty or itself moving; the last looks at rready.
    always_comb begin
        adv = '0;
        adv[LATENCY-1] = !vld[LATENCY-1] || io.rready_i;
        for (int k = LATENCY - 2; k >= 0; k--) begin
            adv[k] = !vld[k+1] || adv[k+1];
        end
    end

    assign gnt    = !vld_p0_q || adv[0];
    assign accept = io.req_i && gnt;

    // ---- S0: operand register ----
    always_comb begin
        vld_p0_d = vld_p0_q;
        op_p0_d  = op_p0_q;
        a_p0_d   = a_p0_q;
        b_p0_d   = b_p0_q;
        c_p0_d   = c_p0_q;
        imm_p0_d = imm_p0_q;
        sub_p0_d = sub_p0_q;
        sgn_p0_d = sgn_p0_q;
        tag_p0_d = tag_p0_q;
        if (adv[0]) begin
            vld_p0_d = 1'b0;
        end
        if (accept) begin
            vld_p0_d = 1'b1;
            op_p0_d  = io.operator_i;
            a_p0_d   = io.op_a_i;
            b_p0_d   = io.op_b_i;
            c_p0_d   = io.op_c_i;
            imm_p0_d = io.imm_i;
            sub_p0_d = io.short_subword_i;
            sgn_p0_d = io.short_signed_i;
            tag_p0_d = io.tag_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_p0_q <= 1'b0;
            op_p0_q  <= '0;
            a_p0_q   <= '0;
            b_p0_q   <= '0;
            c_p0_q   <= '0;
            imm_p0_q <= '0;
            sub_p0_q <= 1'b0;
            sgn_p0_q <= '0;
            tag_p0_q <= '0;
        end else begin
            vld_p0_q <= vld_p0_d;
            op_p0_q  <= op_p0_d;
            a_p0_q   <= a_p0_d;
            b_p0_q   <= b_p0_d;
            c_p0_q   <= c_p0_d;
            imm_p0_q <= imm_p0_d;
            sub_p0_q <= sub_p0_d;
            sgn_p0_q <= sgn_p0_d;
            tag_p0_q <= tag_p0_d;
        end
    end

    // ---- S1..S(LATENCY-1): result return stages ----
    for (genvar k = 1; k < LATENCY; k++) begin : g_stage
        logic                 vld_q;
        logic [31:0]          res_q;
        logic [TAG_WIDTH-1:0] tag_q;
        logic                 err_q;

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                vld_q <= 1'b0;
                res_q <= '0;
                tag_q <= '0;
                err_q <= 1'b0;
            end else if (adv[k]) begin
                vld_q <= vld[k-1];
                if (vld[k-1]) begin
                    res_q <= res[k-1];
                    tag_q <= tag[k-1];
                    err_q <= err[k-1];
                end
            end
        end

        assign vld[k] = vld_q;
        assign res[k] = res_q;
        assign tag[k] = tag_q;
        assign err[k] = err_q;
    end

    assign io.gnt_o               = gnt;
    assign io.mul_operator_o      = op_p0_q;
    assign io.mul_op_a_o          = a_p0_q;
    assign io.mul_op_b_o          = b_p0_q;
    assign io.mul_op_c_o          = c_p0_q;
    assign io.mul_imm_o           = imm_p0_q;
    assign io.mul_short_subword_o = sub_p0_q;
    assign io.mul_short_signed_o  = sgn_p0_q;

    assign io.rvalid_o = vld[LATENCY-1];
    assign io.result_o = vld[LATENCY-1] ? res[LATENCY-1] : 32'h0;
    assign io.tag_o    = tag[LATENCY-1];
    assign io.err_o    = vld[LATENCY-1] && err[LATENCY-1];
    assign io.busy_o   = |vld;
endmodule
